// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_pkg
//  Description : Shared definitions for the multi-cycle ARMv8-subset control
//                path: FSM state codes, opcode values/masks, extender-select
//                and ALU-control codes, and the instruction-class enum.
//                Optional feature macro used by importers: MOVZ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    // Immediate-extender select
    localparam logic [2:0] c_SIGN_I    = 3'b000;
    localparam logic [2:0] c_SIGN_D    = 3'b001;
    localparam logic [2:0] c_SIGN_B    = 3'b010;
    localparam logic [2:0] c_SIGN_CB   = 3'b011;
    localparam logic [2:0] c_SIGN_MOVZ = 3'b100;

    // ALU operation codes
    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_ORR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_PASSB = 4'b0111;

    // Opcode values (IR[31:21]); don't-care bits are zero in the value and
    // cleared in the matching mask.
    localparam logic [10:0] c_OP_LDUR = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR = 11'b11111000000;
    localparam logic [10:0] c_OP_ADD  = 11'b10001011000;
    localparam logic [10:0] c_OP_SUB  = 11'b11001011000;
    localparam logic [10:0] c_OP_AND  = 11'b10001010000;
    localparam logic [10:0] c_OP_ORR  = 11'b10101010000;
    localparam logic [10:0] c_OP_ADDI = 11'b10010001000;
    localparam logic [10:0] c_OP_SUBI = 11'b11010001000;
    localparam logic [10:0] c_OP_B    = 11'b00010100000;
    localparam logic [10:0] c_OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] c_OP_MOVZ = 11'b11010010100;

    localparam logic [10:0] c_MSK_FULL = 11'b11111111111;
    localparam logic [10:0] c_MSK_IMM  = 11'b11111111110;
    localparam logic [10:0] c_MSK_B    = 11'b11111100000;
    localparam logic [10:0] c_MSK_CBZ  = 11'b11111111000;
    localparam logic [10:0] c_MSK_MOVZ = 11'b11111111100;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_D_LD,
        CLS_D_ST,
        CLS_B,
        CLS_CB,
        CLS_MOVZ,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] msk);
        return ((op ^ val) & msk) == 11'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Bundle between the control FSM and the datapath/memory.
//                master : control FSM (drives enables/selects, MemReq)
//                slave  : datapath + memory (drives Opcode, Zero, MemAck)
//  Ports       : Opcode[10:0], Zero, MemAck (to FSM); MemReq, MemWrite,
//                InstrSel, IRWrite, PCWrite, PCSrc, SignOp[2:0], ALUSrc,
//                ALUCtrl[3:0], Reg2Loc, RegWrite, MemToReg, Fault (from FSM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemAck;
    logic        MemReq;
    logic        MemWrite;
    logic        InstrSel;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic [2:0]  SignOp;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        Reg2Loc;
    logic        RegWrite;
    logic        MemToReg;
    logic        Fault;

    modport master (
        input  Opcode, Zero, MemAck,
        output MemReq, MemWrite, InstrSel, IRWrite, PCWrite, PCSrc, SignOp,
               ALUSrc, ALUCtrl, Reg2Loc, RegWrite, MemToReg, Fault
    );

    modport slave (
        output Opcode, Zero, MemAck,
        input  MemReq, MemWrite, InstrSel, IRWrite, PCWrite, PCSrc, SignOp,
               ALUSrc, ALUCtrl, Reg2Loc, RegWrite, MemToReg, Fault
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_opcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_opcode_decoder
//  Description : Combinational opcode decoder. Maps IR[31:21] to an
//                instruction class plus extender select, ALU operation,
//                ALU B-source and register-port-B select.
//                MOVZ_EN: when defined, MOVZ decodes as a pass-B immediate
//                move; otherwise MOVZ is reported as illegal.
//  Ports       : i_opcode[10:0] in; o_cls, o_sign_op[2:0], o_alu_ctrl[3:0],
//                o_alu_src, o_reg2loc out
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_opcode_decoder
    import multicycle_pkg::*;
(
    input  logic [10:0]  i_opcode,
    output instr_class_e o_cls,
    output logic [2:0]   o_sign_op,
    output logic [3:0]   o_alu_ctrl,
    output logic         o_alu_src,
    output logic         o_reg2loc
);

    always_comb begin
        o_cls      = CLS_ILLEGAL;
        o_sign_op  = c_SIGN_I;
        o_alu_ctrl = c_ALU_AND;
        o_alu_src  = 1'b0;
        o_reg2loc  = 1'b0;

        if (op_match(i_opcode, c_OP_LDUR, c_MSK_FULL)) begin
            o_cls      = CLS_D_LD;
            o_sign_op  = c_SIGN_D;
            o_alu_ctrl = c_ALU_ADD;
            o_alu_src  = 1'b1;
        end else if (op_match(i_opcode, c_OP_STUR, c_MSK_FULL)) begin
            // Store data comes from Rt, so port B must read Rt.
            o_cls      = CLS_D_ST;
            o_sign_op  = c_SIGN_D;
            o_alu_ctrl = c_ALU_ADD;
            o_alu_src  = 1'b1;
            o_reg2loc  = 1'b1;
        end else if (op_match(i_opcode, c_OP_ADD, c_MSK_FULL)) begin
            o_cls      = CLS_R;
            o_alu_ctrl = c_ALU_ADD;
        end else if (op_match(i_opcode, c_OP_SUB, c_MSK_FULL)) begin
            o_cls      = CLS_R;
            o_alu_ctrl = c_ALU_SUB;
        end else if (op_match(i_opcode, c_OP_AND, c_MSK_FULL)) begin
            o_cls      = CLS_R;
            o_alu_ctrl = c_ALU_AND;
        end else if (op_match(i_opcode, c_OP_ORR, c_MSK_FULL)) begin
            o_cls      = CLS_R;
            o_alu_ctrl = c_ALU_ORR;
        end else if (op_match(i_opcode, c_OP_ADDI, c_MSK_IMM)) begin
            o_cls      = CLS_I;
            o_alu_ctrl = c_ALU_ADD;
            o_alu_src  = 1'b1;
        end else if (op_match(i_opcode, c_OP_SUBI, c_MSK_IMM)) begin
            o_cls      = CLS_I;
            o_alu_ctrl = c_ALU_SUB;
            o_alu_src  = 1'b1;
        end else if (op_match(i_opcode, c_OP_B, c_MSK_B)) begin
            o_cls      = CLS_B;
            o_sign_op  = c_SIGN_B;
        end else if (op_match(i_opcode, c_OP_CBZ, c_MSK_CBZ)) begin
            // Rt is passed straight through the ALU to drive the Zero flag.
            o_cls      = CLS_CB;
            o_sign_op  = c_SIGN_CB;
            o_alu_ctrl = c_ALU_PASSB;
            o_reg2loc  = 1'b1;
        end
`ifdef MOVZ_EN
        else if (op_match(i_opcode, c_OP_MOVZ, c_MSK_MOVZ)) begin
            o_cls      = CLS_MOVZ;
            o_sign_op  = c_SIGN_MOVZ;
            o_alu_ctrl = c_ALU_PASSB;
            o_alu_src  = 1'b1;
        end
`else
        else if (op_match(i_opcode, c_OP_MOVZ, c_MSK_MOVZ)) begin
            // Without MOVZ support the opcode must trap, and the MOVZ
            // extender code is never produced.
            o_cls      = CLS_ILLEGAL;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for the ARMv8-subset CPU. Sequences
//                FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data
//                memory, one instruction at a time, with a MemReq/MemAck
//                handshake and a memory-wait timeout. Illegal opcodes and
//                timeouts park the FSM in HALT with a sticky Fault.
//                MOVZ_EN: enables MOVZ decode (see opcode decoder).
//  Ports       : CLK, Reset (async, active-high); bus (multicycle_ctrl_if
//                master modport) carrying Opcode/Zero/MemAck in and all
//                enables/selects/Fault out.
//  Parameters  : MEM_TIMEOUT - cycles of unanswered MemReq before Fault
//                (1..255, 8-bit counter)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)(
    input  logic              CLK,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [7:0]   cnt_q,   cnt_d;
    logic         fault_q, fault_d;
    // Held low by Reset so every output is 0 while Reset is asserted; the
    // first FETCH request appears one edge after Reset is released.
    logic         run_q;

    instr_class_e w_cls;
    logic [2:0]   w_dec_sign_op;
    logic [3:0]   w_dec_alu_ctrl;
    logic         w_dec_alu_src;
    logic         w_dec_reg2loc;

    logic         w_mem_req;
    logic         w_mem_write;
    logic         w_instr_sel;
    logic         w_ir_write;
    logic         w_pc_write;
    logic         w_pc_src;
    logic [2:0]   w_sign_op;
    logic         w_alu_src;
    logic [3:0]   w_alu_ctrl;
    logic         w_reg2loc;
    logic         w_reg_write;
    logic         w_mem_to_reg;

    multicycle_ctrl_opcode_decoder u_opcode_decoder (
        .i_opcode   (bus.Opcode),
        .o_cls      (w_cls),
        .o_sign_op  (w_dec_sign_op),
        .o_alu_ctrl (w_dec_alu_ctrl),
        .o_alu_src  (w_dec_alu_src),
        .o_reg2loc  (w_dec_reg2loc)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_d      = fault_q;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_instr_sel  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_sign_op    = c_SIGN_I;
        w_alu_src    = 1'b0;
        w_alu_ctrl   = c_ALU_AND;
        w_reg2loc    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;

        if (run_q) begin
            case (state_q)
                c_ST_FETCH: begin
                    w_mem_req   = 1'b1;
                    w_instr_sel = 1'b1;
                    // IR load and PC+4 happen in the acknowledge cycle itself.
                    if (bus.MemAck) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        state_d    = c_ST_DECODE;
                    end
                end

                c_ST_DECODE: begin
                    if (w_cls == CLS_ILLEGAL) begin
                        state_d = c_ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        w_sign_op = w_dec_sign_op;
                        w_reg2loc = w_dec_reg2loc;
                        state_d   = c_ST_EXEC;
                    end
                end

                c_ST_EXEC: begin
                    w_sign_op  = w_dec_sign_op;
                    w_reg2loc  = w_dec_reg2loc;
                    w_alu_src  = w_dec_alu_src;
                    w_alu_ctrl = w_dec_alu_ctrl;
                    case (w_cls)
                        CLS_R, CLS_I, CLS_MOVZ: state_d = c_ST_WB;
                        CLS_D_LD, CLS_D_ST:     state_d = c_ST_MEM;
                        // The datapath still holds the branch's own PC
                        // alongside PC+4; PCSrc=1 adds the offset to it.
                        CLS_B: begin
                            w_pc_write = 1'b1;
                            w_pc_src   = 1'b1;
                            state_d    = c_ST_FETCH;
                        end
                        CLS_CB: begin
                            w_pc_write = bus.Zero;
                            w_pc_src   = bus.Zero;
                            state_d    = c_ST_FETCH;
                        end
                        default: begin
                            state_d = c_ST_HALT;
                            fault_d = 1'b1;
                        end
                    endcase
                end

                c_ST_MEM: begin
                    w_mem_req   = 1'b1;
                    w_mem_write = (w_cls == CLS_D_ST);
                    w_sign_op   = w_dec_sign_op;
                    w_reg2loc   = w_dec_reg2loc;
                    if (bus.MemAck) begin
                        state_d = (w_cls == CLS_D_ST) ? c_ST_FETCH : c_ST_WB;
                    end
                end

                c_ST_WB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = (w_cls == CLS_D_LD);
                    w_sign_op    = w_dec_sign_op;
                    w_reg2loc    = w_dec_reg2loc;
                    state_d      = c_ST_FETCH;
                end

                c_ST_HALT: begin
                    state_d = c_ST_HALT;
                end

                default: begin
                    state_d = c_ST_HALT;
                    fault_d = 1'b1;
                end
            endcase

            // Wait counter: an acknowledge in the limit cycle is honoured
            // because the limit is only tested when MemAck is absent.
            if (w_mem_req) begin
                if (bus.MemAck) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = c_ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= c_ST_FETCH;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            run_q   <= 1'b1;
        end
    end

    assign bus.MemReq   = w_mem_req;
    assign bus.MemWrite = w_mem_write;
    assign bus.InstrSel = w_instr_sel;
    assign bus.IRWrite  = w_ir_write;
    assign bus.PCWrite  = w_pc_write;
    assign bus.PCSrc    = w_pc_src;
    assign bus.SignOp   = w_sign_op;
    assign bus.ALUSrc   = w_alu_src;
    assign bus.ALUCtrl  = w_alu_ctrl;
    assign bus.Reg2Loc  = w_reg2loc;
    assign bus.RegWrite = w_reg_write;
    assign bus.MemToReg = w_mem_to_reg;
    assign bus.Fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. A per-instruction
//                reference model expands each opcode into its expected
//                cycle-by-cycle output pattern; directed and random
//                instructions are compared against the DUT every cycle.
//                MOVZ_EN: selects the expected MOVZ behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [2:0] K_ALU = 3'd0;
    localparam logic [2:0] K_LD  = 3'd1;
    localparam logic [2:0] K_ST  = 3'd2;
    localparam logic [2:0] K_B   = 3'd3;
    localparam logic [2:0] K_CB  = 3'd4;
    localparam logic [2:0] K_BAD = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] so;
        logic       asrc;
        logic [3:0] actl;
        logic       r2l;
    } info_t;

    logic CLK = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    logic [10:0] cur_op   = 11'd0;
    logic        cur_zero = 1'b0;

    // LDUR STUR ADD SUB AND ORR ADDI SUBI B CBZ MOVZ
    logic [10:0] bases [11] = '{11'b11111000010, 11'b11111000000,
        11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
        11'b10010001000, 11'b11010001000, 11'b00010100000, 11'b10110100000,
        11'b11010010100};
    int wild [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 5, 3, 2};

    always #5 CLK = ~CLK;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(255)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic logic [17:0] obs();
        return {bus.MemReq, bus.MemWrite, bus.InstrSel, bus.IRWrite,
                bus.PCWrite, bus.PCSrc, bus.SignOp, bus.ALUSrc, bus.ALUCtrl,
                bus.Reg2Loc, bus.RegWrite, bus.MemToReg, bus.Fault};
    endfunction

    function automatic logic [17:0] mk(input logic mreq, mw, isel, irw,
                                       input logic pcw, pcs,
                                       input logic [2:0] so,
                                       input logic asrc,
                                       input logic [3:0] actl,
                                       input logic r2l, rw, m2r, flt);
        return {mreq, mw, isel, irw, pcw, pcs, so, asrc, actl, r2l, rw, m2r, flt};
    endfunction

    // Reference decode, taken directly from the opcode table.
    function automatic info_t ref_decode(input logic [10:0] op);
        info_t i;
        i = '{kind: K_BAD, so: 3'b000, asrc: 1'b0, actl: 4'b0000, r2l: 1'b0};
        casez (op)
            11'b11111000010: i = '{K_LD,  3'b001, 1'b1, 4'b0010, 1'b0};
            11'b11111000000: i = '{K_ST,  3'b001, 1'b1, 4'b0010, 1'b1};
            11'b10001011000: i = '{K_ALU, 3'b000, 1'b0, 4'b0010, 1'b0};
            11'b11001011000: i = '{K_ALU, 3'b000, 1'b0, 4'b0110, 1'b0};
            11'b10001010000: i = '{K_ALU, 3'b000, 1'b0, 4'b0000, 1'b0};
            11'b10101010000: i = '{K_ALU, 3'b000, 1'b0, 4'b0001, 1'b0};
            11'b1001000100?: i = '{K_ALU, 3'b000, 1'b1, 4'b0010, 1'b0};
            11'b1101000100?: i = '{K_ALU, 3'b000, 1'b1, 4'b0110, 1'b0};
            11'b000101?????: i = '{K_B,   3'b010, 1'b0, 4'b0000, 1'b0};
            11'b10110100???: i = '{K_CB,  3'b011, 1'b0, 4'b0111, 1'b1};
`ifdef MOVZ_EN
            11'b110100101??: i = '{K_ALU, 3'b100, 1'b1, 4'b0111, 1'b0};
`else
            11'b110100101??: i.kind = K_BAD;
`endif
            default:         i.kind = K_BAD;
        endcase
        return i;
    endfunction

    function automatic logic [10:0] gen_op(input int k);
        logic [10:0] r;
        r = 11'($urandom);
        return bases[k] | (r & ((11'd1 << wild[k]) - 11'd1));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare shortly after.
    task automatic step(input string tag, input logic ack, input logic [17:0] exp);
        logic [17:0] o;
        @(negedge CLK);
        bus.Opcode = cur_op;
        bus.Zero   = cur_zero;
        bus.MemAck = ack;
        #1;
        o = obs();
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [17:0] exp);
        logic [17:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        bus.MemAck = 1'b0;
        Reset      = 1'b1;
        #1 check_now("reset_async", 18'd0);
        @(negedge CLK);
        #1 check_now("reset_hold", 18'd0);
        @(negedge CLK);
        Reset = 1'b0;
        #1 check_now("reset_release", 18'd0);
    endtask

    // Runs one instruction end-to-end; an illegal one is followed by
    // 20 cycles in HALT with the Fault flag up.
    task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic zero);
        info_t i;
        logic  taken;
        i        = ref_decode(op);
        cur_op   = op;
        cur_zero = zero;
        for (int n = 0; n < fw; n++)
            step("fetch_wait", 1'b0, mk(1,0,1,0,0,0,3'b000,0,4'b0000,0,0,0,0));
        step("fetch_ack", 1'b1, mk(1,0,1,1,1,0,3'b000,0,4'b0000,0,0,0,0));
        if (i.kind == K_BAD) begin
            step("decode_bad", rbit(), 18'd0);
            for (int n = 0; n < 20; n++)
                step("halt", rbit(), mk(0,0,0,0,0,0,3'b000,0,4'b0000,0,0,0,1));
            return;
        end
        step("decode", rbit(), mk(0,0,0,0,0,0,i.so,0,4'b0000,i.r2l,0,0,0));
        taken = (i.kind == K_B) || (i.kind == K_CB && zero);
        step("exec", rbit(), mk(0,0,0,0,taken,taken,i.so,i.asrc,i.actl,i.r2l,0,0,0));
        if (i.kind == K_LD || i.kind == K_ST) begin
            for (int n = 0; n < mw; n++)
                step("mem_wait", 1'b0,
                     mk(1,i.kind == K_ST,0,0,0,0,i.so,0,4'b0000,i.r2l,0,0,0));
            step("mem_ack", 1'b1,
                 mk(1,i.kind == K_ST,0,0,0,0,i.so,0,4'b0000,i.r2l,0,0,0));
        end
        if (i.kind == K_ALU || i.kind == K_LD)
            step("wb", rbit(),
                 mk(0,0,0,0,0,0,i.so,0,4'b0000,i.r2l,1,i.kind == K_LD,0));
    endtask

    initial begin
        Reset      = 1'b1;
        bus.Opcode = 11'd0;
        bus.Zero   = 1'b0;
        bus.MemAck = 1'b0;
        do_reset();

        // Directed: ADD with three fetch wait cycles, LDUR, branches.
        run_instr(gen_op(2), 3, 0, 1'b0);
        run_instr(gen_op(0), 0, 0, 1'b1);
        run_instr(gen_op(1), 2, 3, 1'b0);
        run_instr(gen_op(9), 1, 0, 1'b1);
        run_instr(gen_op(9), 1, 0, 1'b0);
        run_instr(gen_op(8), 0, 0, 1'b1);

        // Acknowledge arrives in the very cycle the wait count reaches the limit.
        run_instr(gen_op(6), 254, 0, 1'b0);
        run_instr(gen_op(0), 0, 254, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 40; n++)
            run_instr(gen_op($urandom_range(0, 9)), $urandom_range(0, 4),
                      $urandom_range(0, 4), rbit());

        // Reset while a data request is outstanding.
        cur_op = gen_op(0);
        step("rst_fetch_ack", 1'b1, mk(1,0,1,1,1,0,3'b000,0,4'b0000,0,0,0,0));
        step("rst_decode", 1'b0, mk(0,0,0,0,0,0,3'b001,0,4'b0000,0,0,0,0));
        step("rst_exec", 1'b0, mk(0,0,0,0,0,0,3'b001,1,4'b0010,0,0,0,0));
        step("rst_mem", 1'b0, mk(1,0,0,0,0,0,3'b001,0,4'b0000,0,0,0,0));
        do_reset();
        run_instr(gen_op(3), 1, 0, 1'b0);

        // MOVZ: executes when enabled, traps otherwise.
        run_instr(gen_op(10), 0, 0, 1'b0);
        if (ref_decode(cur_op).kind == K_BAD) do_reset();

        // Illegal opcode traps and stays halted until Reset.
        run_instr(11'b11111111111, 0, 0, 1'b0);
        do_reset();

        // Memory timeout: 255 unanswered request cycles.
        cur_op = gen_op(2);
        for (int n = 0; n < 255; n++)
            step("timeout_wait", 1'b0, mk(1,0,1,0,0,0,3'b000,0,4'b0000,0,0,0,0));
        for (int n = 0; n < 5; n++)
            step("timeout_halt", rbit(), mk(0,0,0,0,0,0,3'b000,0,4'b0000,0,0,0,1));
        do_reset();
        run_instr(gen_op(5), 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
